// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_pkg
// Description : Shared definitions for the scoreboarded register file:
//               FSM state encoding, default geometry and the helper that
//               identifies the hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // True when addr names register 0 and register 0 is hard-wired to zero.
    function automatic logic is_zero_reg(input logic [31:0] addr, input int zero_reg);
        return (zero_reg != 0) && (addr == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_clr_fsm.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_clr_fsm
// Description : Clear-sweep controller. Walks a pointer over every register
//               after reset or on request, emitting one clear strobe per
//               cycle, then parks in IDLE with ready asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_clr_fsm
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_en,
    output logic              clr_start,
    output logic [ADDR_W-1:0] clr_addr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // State and sweep pointer registers; reset restarts the sweep at entry 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: sweep every entry once (terminal count = all ones), then idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // The array must not be touched while reset is held, only by the sweep proper.
    assign ready     = (state_q == ST_IDLE);
    assign clr_en    = (state_q == ST_CLEAR) && reset;
    assign clr_start = (state_q == ST_IDLE) && clr_req && reset;
    assign clr_addr  = ptr_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file with three combinational read
//               ports, a per-register busy scoreboard for issue, and a
//               sequential clear sweep after reset or on request.
//               Optional macro REGFILE_SB_BYPASS_EN enables same-cycle
//               write-to-read forwarding while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              ready,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              write_sig,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd3,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic              w_ready;
    logic              w_clr_en;
    logic              w_clr_start;
    logic [ADDR_W-1:0] w_clr_addr;

    logic              w_active;
    logic              w_wr_en;
    logic              w_sb_en;
    logic              w_fwd1, w_fwd2, w_fwd3;
    logic [DATA_W-1:0] w_raw1, w_raw2, w_raw3;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    regfile_sb_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .ready     (w_ready),
        .clr_en    (w_clr_en),
        .clr_start (w_clr_start),
        .clr_addr  (w_clr_addr)
    );

    assign ready    = w_ready;
    assign w_active = w_ready && reset;
    assign w_wr_en  = w_active && write_sig && !is_zero_reg(32'(wr), ZERO_REG);
    assign w_sb_en  = w_active && sb_set && !is_zero_reg(32'(sb_addr), ZERO_REG);

    // Array update: the sweep owns the array while clearing, writeback otherwise.
    always_comb begin
        mem_d = mem_q;
        if (w_clr_en) begin
            mem_d[w_clr_addr] = '0;
        end else if (w_wr_en) begin
            mem_d[wr] = wd;
        end
    end

    // Array storage; contents are deliberately not reset, the sweep zeroes them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Scoreboard update: retiring write clears, issue sets, and set wins a tie.
    always_comb begin
        busy_d = busy_q;
        if (w_clr_en || w_clr_start) begin
            busy_d = '0;
        end else begin
            if (w_wr_en) begin
                busy_d[wr] = 1'b0;
            end
            if (w_sb_en) begin
                busy_d[sb_addr] = 1'b1;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign w_raw1 = is_zero_reg(32'(rr1), ZERO_REG) ? '0 : mem_q[rr1];
    assign w_raw2 = is_zero_reg(32'(rr2), ZERO_REG) ? '0 : mem_q[rr2];
    assign w_raw3 = is_zero_reg(32'(wr),  ZERO_REG) ? '0 : mem_q[wr];

`ifdef REGFILE_SB_BYPASS_EN
    // Forward only writes that will actually land, so register 0 stays zero.
    assign w_fwd1 = w_wr_en && (rr1 == wr);
    assign w_fwd2 = w_wr_en && (rr2 == wr);
    assign w_fwd3 = w_wr_en;
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
    assign w_fwd3 = 1'b0;
`endif

    assign rd1   = !w_active ? '0 : (w_fwd1 ? wd : w_raw1);
    assign rd2   = !w_active ? '0 : (w_fwd2 ? wd : w_raw2);
    assign rd3   = !w_active ? '0 : (w_fwd3 ? wd : w_raw3);
    assign busy1 = w_active && !w_fwd1 && busy_q[rr1];
    assign busy2 = w_active && !w_fwd2 && busy_q[rr2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb: directed scenarios then
//               randomized traffic, all checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          reset, clr_req, ready, write_sig, sb_set, busy1, busy2;
    logic [AW-1:0] rr1, rr2, wr, sb_addr;
    logic [DW-1:0] wd, rd1, rd2, rd3;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .ready     (ready),
        .rr1       (rr1),
        .rr2       (rr2),
        .rd1       (rd1),
        .rd2       (rd2),
        .busy1     (busy1),
        .busy2     (busy2),
        .write_sig (write_sig),
        .wr        (wr),
        .wd        (wd),
        .rd3       (rd3),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr)
    );

    // Behavioural model: register values, busy flags, sweep cycles still owed.
    logic [DW-1:0] m_mem  [NR];
    logic          m_busy [NR];
    int            m_clr_left;
    int            n_cmp  = 0;
    int            n_fail = 0;
    int            cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_fwd(input logic [AW-1:0] a);
`ifdef REGFILE_SB_BYPASS_EN
        return write_sig && (wr != 0) && (a == wr);
`else
        return 1'b0 && (a == wr);
`endif
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (!(reset && m_clr_left == 0) || a == 0) return '0;
        if (m_fwd(a)) return wd;
        return m_mem[a];
    endfunction

    function automatic logic m_bz(input logic [AW-1:0] a);
        if (!(reset && m_clr_left == 0) || m_fwd(a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        check("ready", 32'(ready), 32'(m_clr_left == 0));
        check("rd1",   32'(rd1),   32'(m_rd(rr1)));
        check("rd2",   32'(rd2),   32'(m_rd(rr2)));
        check("rd3",   32'(rd3),   32'(m_rd(wr)));
        check("busy1", 32'(busy1), 32'(m_bz(rr1)));
        check("busy2", 32'(busy2), 32'(m_bz(rr2)));
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_clr_left = NR;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else if (m_clr_left > 0) begin
            m_mem[NR - m_clr_left] = '0;
            m_clr_left--;
        end else begin
            if (write_sig && wr != 0) begin
                m_mem[wr]  = wd;
                m_busy[wr] = 1'b0;
            end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
            if (clr_req) begin
                m_clr_left = NR;
                foreach (m_busy[i]) m_busy[i] = 1'b0;
            end
        end
    endtask

    // One cycle: check outputs for the driven inputs, clock, advance the model.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_idle();
        clr_req   = 1'b0;
        write_sig = 1'b0;
        sb_set    = 1'b0;
        rr1 = '0; rr2 = '0; wr = '0; sb_addr = '0; wd = '0;
    endtask

    initial begin
        set_idle();
        reset      = 1'b0;
        m_clr_left = NR;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        @(negedge clk);
        step();

        // Reset sweep length.
        reset = 1'b1;
        cnt   = 0;
        do begin
            step();
            cnt++;
        end while (ready !== 1'b1 && cnt < 50);
        check("reset_sweep_len", 32'(cnt), 32'd8);
        for (int i = 0; i < NR; i++) begin
            rr1 = AW'(i); rr2 = AW'(NR - 1 - i); wr = AW'(i);
            #1 check("swept_zero", 32'(rd1), 32'd0);
            step();
        end

        // Write/read and zero register.
        write_sig = 1'b1; wr = 3'd5; wd = 16'hBEEF; step();
        write_sig = 1'b0; rr1 = 3'd5;
        #1 check("rd1_beef", 32'(rd1), 32'h0000BEEF);
        step();
        write_sig = 1'b1; wr = 3'd0; wd = 16'h1234; step();
        write_sig = 1'b0; rr1 = 3'd0;
        #1 check("rd1_reg0", 32'(rd1), 32'd0);
        step();

        // Scoreboard set, clear by write, and set-wins tie.
        sb_set = 1'b1; sb_addr = 3'd3; step();
        sb_set = 1'b0; rr1 = 3'd3;
        #1 check("busy_set", 32'(busy1), 32'd1);
        step();
        write_sig = 1'b1; wr = 3'd3; wd = 16'h1111; step();
        write_sig = 1'b0;
        #1 check("busy_cleared", 32'(busy1), 32'd0);
        step();
        write_sig = 1'b1; wr = 3'd3; wd = 16'h2222; sb_set = 1'b1; sb_addr = 3'd3; step();
        write_sig = 1'b0; sb_set = 1'b0;
        #1 check("busy_set_wins", 32'(busy1), 32'd1);
        check("tie_data", 32'(rd1), 32'h00002222);
        step();

        // Same-cycle write to a busy register being read.
        write_sig = 1'b1; wr = 3'd6; wd = 16'h0777; step();
        write_sig = 1'b0; sb_set = 1'b1; sb_addr = 3'd6; step();
        sb_set = 1'b0; write_sig = 1'b1; wr = 3'd6; wd = 16'h00A5; rr2 = 3'd6;
`ifdef REGFILE_SB_BYPASS_EN
        #1 check("bypass_rd2", 32'(rd2), 32'h000000A5);
        check("bypass_busy2", 32'(busy2), 32'd0);
`else
        #1 check("nobypass_rd2", 32'(rd2), 32'h00000777);
        check("nobypass_busy2", 32'(busy2), 32'd1);
`endif
        step();
        set_idle();

        // Clear request with an ignored write mid-sweep.
        for (int i = 1; i < NR; i++) begin
            write_sig = 1'b1; wr = AW'(i); wd = DW'(16'h1000 + 16'(i) * 16'h0111);
            step();
        end
        set_idle();
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        cnt = 0;
        do begin
            write_sig = (cnt == 4);
            wr = 3'd2; wd = 16'hFFFF;
            step();
            cnt++;
        end while (ready !== 1'b1 && cnt < 50);
        set_idle();
        check("clr_sweep_len", 32'(cnt), 32'd8);
        for (int i = 0; i < NR; i++) begin
            rr1 = AW'(i); wr = AW'(i);
            #1 check("clr_zero", 32'(rd1), 32'd0);
            step();
        end

        // Reset in the middle of a sweep restarts it.
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        repeat (4) step();
        reset = 1'b0; step();
        reset = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (ready !== 1'b1 && cnt < 50);
        check("restart_sweep_len", 32'(cnt), 32'd8);

        // Randomized traffic against the model.
        repeat (500) begin
            reset     = ($urandom_range(0, 99) != 0);
            clr_req   = ($urandom_range(0, 39) == 0);
            write_sig = 1'($urandom);
            sb_set    = 1'($urandom);
            rr1       = AW'($urandom);
            rr2       = AW'($urandom);
            wr        = AW'($urandom);
            sb_addr   = AW'($urandom);
            wd        = DW'($urandom);
            step();
        end
        reset = 1'b1;
        set_idle();
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 8x16 register file.
- Adds configurable width and depth, three read ports, a per-register busy scoreboard for the issue stage, and a sequential clear sweep.
- The clear sweep runs after reset or on request, so the array can map to memory that clears one entry per cycle.
- Sits between decode/issue and writeback; issue reads operands and busy flags, writeback drives the write port.

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 3: register address width.
- NUM_REGS = 2**ADDR_W: number of registers (derived; not overridable).
- ZERO_REG, 1: when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- clr_req  in  1  request a full clear sweep; sampled only in IDLE.
- ready  out  1  1 in IDLE; 0 during the clear sweep.
- rr1  in  ADDR_W  read address, port 1.
- rr2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  read data, port 1 (combinational).
- rd2  out  DATA_W  read data, port 2 (combinational).
- busy1  out  1  scoreboard bit of rr1.
- busy2  out  1  scoreboard bit of rr2.
- write_sig  in  1  write enable.
- wr  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- rd3  out  DATA_W  read data at wr (readback of the write target).
- sb_set  in  1  mark register sb_addr busy (instruction issued).
- sb_addr  in  ADDR_W  scoreboard set address.

Behaviour:
- Reset: reset=0 at a rising edge puts the FSM in CLEAR with clr_ptr=0 and all busy bits 0.
  - ready=0 from the first edge after reset is sampled low.
  - While reset is held low, rd1/rd2/rd3=0.
  - Array contents are not zeroed by reset itself; the sweep zeroes them.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to reg[clr_ptr], then clr_ptr+1. After clr_ptr==NUM_REGS-1 is written, go to IDLE. CLEAR lasts exactly NUM_REGS cycles.
  - IDLE: ready=1. clr_req=1 moves to CLEAR with clr_ptr=0 and clears all busy bits.
  - reset low during CLEAR restarts the sweep at 0.
- During CLEAR:
  - rd1/rd2/rd3 read 0 and busy1/busy2 read 0.
  - write_sig and sb_set are ignored; no error is flagged, and the upstream stage must stall on ready.
- Write (IDLE only): write_sig=1 and not (ZERO_REG and wr==0) stores wd into reg[wr] at the edge. The write also clears busy[wr].
- Reads: rd1=reg[rr1], rd2=reg[rr2], rd3=reg[wr].
  - All reads are combinational, with zero latency from address to data.
  - With ZERO_REG, address 0 always reads 0.
- Scoreboard (IDLE only):
  - sb_set=1 sets busy[sb_addr]; ignored for reg 0 when ZERO_REG.
  - A write with sb_set=1 and sb_addr==wr in the same cycle leaves busy=1 (set wins; the new producer overrides the retiring one). Data is still written.
  - busy1/busy2 are combinational from the current busy bits. Without BYPASS_EN they do not reflect same-cycle sets or clears.
- Widths: all data is exactly DATA_W; no extension or truncation. clr_ptr is ADDR_W+1 bits, or a terminal-count compare on ADDR_W bits.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: write-to-read forwarding in IDLE.
  - If write_sig=1, the write is not suppressed (ZERO_REG and wr==0), and rrN==wr, then rdN=wd in the same cycle and busyN=0.
  - rd3=wd when write_sig=1.
  - Forwarding never applies during CLEAR.
- Not defined: reads return the pre-edge array value; busy flags show pre-edge state.

Decomposition:
- Package regfile_sb_pkg holds:
  - FSM state encoding (ST_CLEAR, ST_IDLE).
  - Default DATA_W/ADDR_W constants.
  - A function is_zero_reg(addr, ZERO_REG).
- One sub-module, regfile_sb_clr_fsm: state register, clr_ptr, ready.
  - It outputs a clear strobe and clear address into the array/scoreboard logic in regfile_sb.

Test Plan:
- Reset sweep: reset=0 for 2 cycles, then 1 -> ready=0 for exactly 8 cycles (defaults), then 1; all rd reads 0; busy all 0.
- Write/read: IDLE, write wr=5 wd=16'hBEEF -> next cycle rr1=5 gives rd1=16'hBEEF; write wr=0 wd=16'h1234 -> rd of reg 0 stays 0.
- Scoreboard:
  - sb_set addr 3 -> busy1=1 at rr1=3 next cycle.
  - Write wr=3 -> busy1=0 next cycle.
  - Simultaneous sb_set=3 and write wr=3 -> busy stays 1 and data is updated.
- Clear request: load regs 1-7 with nonzero values, pulse clr_req -> ready low for 8 cycles; a write_sig to reg 2 in the middle of the sweep is ignored; afterwards all regs read 0.
- Reset mid-sweep: assert reset at sweep cycle 4 -> the sweep restarts and ready stays low for 8 cycles after reset is released.
- Bypass (REGFILE_SB_BYPASS_EN): write wr=6 wd=16'h00A5 with rr2=6 and busy[6]=1 -> same-cycle rd2=16'h00A5, busy2=0. Without the macro: rd2=old value, busy2=1.
